// File: rtl/ialu_issue.sv
// rtl/ialu_issue.sv - RV64I integer ALU issue stage with registered decode and writeback
//
// Purpose: two-stage pipeline around an external combinational ALU.
//   D stage decodes an RV64I OP/OP-IMM/OP-32/OP-IMM-32 instruction into
//   one-hot-ish ALU controls and operands; W stage captures the ALU result
//   and flags for the writeback consumer. Only DW=64 is supported (6-bit shamt).
//
// Ports:
//   clk, nreset                 clock, asynchronous active-low reset
//   in_valid/in_ready           instruction beat handshake
//   in_instr, in_rs1, in_rs2    instruction word and register-file operands
//   op_rs1, op_rs2, de_*        registered ALU operands and controls (D stage)
//   ia_result, ia_*             combinational ALU result and flags
//   wb_valid/wb_ready           writeback handshake
//   wb_rd, wb_result, wb_*      captured destination, result, flags, illegal

module ialu_issue #(
   parameter int DW = 64
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_instr,
   input  logic [DW-1:0] in_rs1,
   input  logic [DW-1:0] in_rs2,
   output logic [DW-1:0] op_rs1,
   output logic [DW-1:0] op_rs2,
   output logic          de_add,
   output logic          de_sub,
   output logic          de_sll,
   output logic          de_srl,
   output logic          de_sra,
   output logic          de_and,
   output logic          de_or,
   output logic          de_xor,
   output logic          de_sltu,
   output logic          de_slt,
   output logic          de_sext,
   input  logic [DW-1:0] ia_result,
   input  logic          ia_zero,
   input  logic          ia_carry,
   input  logic          ia_neg,
   input  logic          ia_over,
   output logic          wb_valid,
   input  logic          wb_ready,
   output logic [4:0]    wb_rd,
   output logic [DW-1:0] wb_result,
   output logic          wb_zero,
   output logic          wb_carry,
   output logic          wb_neg,
   output logic          wb_over,
   output logic          wb_illegal
);

   // Control vector bit positions.
   localparam int C_ADD  = 10;
   localparam int C_SUB  = 9;
   localparam int C_SLL  = 8;
   localparam int C_SRL  = 7;
   localparam int C_SRA  = 6;
   localparam int C_AND  = 5;
   localparam int C_OR   = 4;
   localparam int C_XOR  = 3;
   localparam int C_SLTU = 2;
   localparam int C_SLT  = 1;
   localparam int C_SEXT = 0;
   localparam int CW     = 11;

   // ---------------- decode ----------------
   logic [6:0]    opc;
   logic [2:0]    f3;
   logic [6:0]    f7;
   logic          is_op, is_imm, is_op32, is_imm32;
   logic          is_reg, is_word;
   logic          dec_legal;
   logic [CW-1:0] ctl_raw;
   logic [CW-1:0] dec_ctl;
   logic [DW-1:0] dec_rs2;
   logic          unused_rs_fields;

   assign opc      = in_instr[6:0];
   assign f3       = in_instr[14:12];
   assign f7       = in_instr[31:25];
   assign is_op    = (opc == 7'b0110011);
   assign is_imm   = (opc == 7'b0010011);
   assign is_op32  = (opc == 7'b0111011);
   assign is_imm32 = (opc == 7'b0011011);
   assign is_reg   = is_op | is_op32;
   assign is_word  = is_op32 | is_imm32;

   // Register source indices are consumed by the register file, not here.
   assign unused_rs_fields = ^in_instr[19:15];

   always_comb begin
      ctl_raw   = '0;
      dec_legal = is_op | is_imm | is_op32 | is_imm32;
      case (f3)
         3'b000: begin
            ctl_raw[C_ADD] = 1'b1;
            if (is_reg) begin
               if (f7 == 7'b0100000) ctl_raw[C_SUB] = 1'b1;
               else if (f7 != 7'b0000000) dec_legal = 1'b0;
            end
         end
         3'b001: begin
            ctl_raw[C_SLL] = 1'b1;
            // OP-IMM keeps a 6-bit shamt, so only [31:26] are checked there.
            if (is_imm) dec_legal = dec_legal & (in_instr[31:26] == 6'b000000);
            else        dec_legal = dec_legal & (f7 == 7'b0000000);
         end
         3'b101: begin
            if (in_instr[30]) ctl_raw[C_SRA] = 1'b1;
            else              ctl_raw[C_SRL] = 1'b1;
            if (is_imm)
               dec_legal = dec_legal & ((in_instr[31:26] == 6'b000000) |
                                        (in_instr[31:26] == 6'b010000));
            else
               dec_legal = dec_legal & ((f7 == 7'b0000000) | (f7 == 7'b0100000));
         end
         default: begin
            // slt/sltu/xor/or/and: no word forms, funct7 zero for register forms.
            case (f3)
               3'b010:  begin ctl_raw[C_SUB] = 1'b1; ctl_raw[C_SLT]  = 1'b1; end
               3'b011:  begin ctl_raw[C_SUB] = 1'b1; ctl_raw[C_SLTU] = 1'b1; end
               3'b100:  ctl_raw[C_XOR] = 1'b1;
               3'b110:  ctl_raw[C_OR]  = 1'b1;
               default: ctl_raw[C_AND] = 1'b1;
            endcase
            if (is_word) dec_legal = 1'b0;
            if (is_reg && (f7 != 7'b0000000)) dec_legal = 1'b0;
         end
      endcase
      ctl_raw[C_SEXT] = is_word;
      dec_ctl = dec_legal ? ctl_raw : '0;
   end

   assign dec_rs2 = (is_imm | is_imm32) ? {{(DW-12){in_instr[31]}}, in_instr[31:20]} : in_rs2;

   // ---------------- pipeline state ----------------
   logic          d_valid_q, d_valid_d;
   logic [DW-1:0] op_rs1_q, op_rs1_d;
   logic [DW-1:0] op_rs2_q, op_rs2_d;
   logic [CW-1:0] ctl_q, ctl_d;
   logic [4:0]    rd_q, rd_d;
   logic          ill_q, ill_d;
   logic          wb_valid_q, wb_valid_d;
   logic [4:0]    wb_rd_q, wb_rd_d;
   logic [DW-1:0] wb_result_q, wb_result_d;
   logic [3:0]    wb_flags_q, wb_flags_d;
   logic          wb_ill_q, wb_ill_d;
   logic          d_adv, accept;

   assign d_adv    = d_valid_q & (~wb_valid_q | wb_ready);
   assign in_ready = ~d_valid_q | d_adv;
   assign accept   = in_valid & in_ready;

   always_comb begin
      d_valid_d = d_valid_q;
      op_rs1_d  = op_rs1_q;
      op_rs2_d  = op_rs2_q;
      ctl_d     = ctl_q;
      rd_d      = rd_q;
      ill_d     = ill_q;
      if (accept) begin
         d_valid_d = 1'b1;
         op_rs1_d  = in_rs1;
         op_rs2_d  = dec_rs2;
         ctl_d     = dec_ctl;
         rd_d      = in_instr[11:7];
         ill_d     = ~dec_legal;
      end else if (d_adv) begin
         // Controls must read zero while D is empty.
         d_valid_d = 1'b0;
         ctl_d     = '0;
      end

      wb_valid_d  = wb_valid_q;
      wb_rd_d     = wb_rd_q;
      wb_result_d = wb_result_q;
      wb_flags_d  = wb_flags_q;
      wb_ill_d    = wb_ill_q;
      if (d_adv) begin
         wb_valid_d  = 1'b1;
         wb_rd_d     = rd_q;
         wb_ill_d    = ill_q;
         // Illegal beats report a clean zero result regardless of the ALU.
         wb_result_d = ill_q ? '0 : ia_result;
         wb_flags_d  = ill_q ? 4'b0000 : {ia_zero, ia_carry, ia_neg, ia_over};
      end else if (wb_valid_q & wb_ready) begin
         wb_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         d_valid_q   <= 1'b0;
         op_rs1_q    <= '0;
         op_rs2_q    <= '0;
         ctl_q       <= '0;
         rd_q        <= '0;
         ill_q       <= 1'b0;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= '0;
         wb_result_q <= '0;
         wb_flags_q  <= '0;
         wb_ill_q    <= 1'b0;
      end else begin
         d_valid_q   <= d_valid_d;
         op_rs1_q    <= op_rs1_d;
         op_rs2_q    <= op_rs2_d;
         ctl_q       <= ctl_d;
         rd_q        <= rd_d;
         ill_q       <= ill_d;
         wb_valid_q  <= wb_valid_d;
         wb_rd_q     <= wb_rd_d;
         wb_result_q <= wb_result_d;
         wb_flags_q  <= wb_flags_d;
         wb_ill_q    <= wb_ill_d;
      end
   end

   // ---------------- outputs ----------------
   assign op_rs1  = op_rs1_q;
   assign op_rs2  = op_rs2_q;
   assign de_add  = ctl_q[C_ADD];
   assign de_sub  = ctl_q[C_SUB];
   assign de_sll  = ctl_q[C_SLL];
   assign de_srl  = ctl_q[C_SRL];
   assign de_sra  = ctl_q[C_SRA];
   assign de_and  = ctl_q[C_AND];
   assign de_or   = ctl_q[C_OR];
   assign de_xor  = ctl_q[C_XOR];
   assign de_sltu = ctl_q[C_SLTU];
   assign de_slt  = ctl_q[C_SLT];
   assign de_sext = ctl_q[C_SEXT];

   assign wb_valid   = wb_valid_q;
   assign wb_rd      = wb_rd_q;
   assign wb_result  = wb_result_q;
   assign wb_zero    = wb_flags_q[3];
   assign wb_carry   = wb_flags_q[2];
   assign wb_neg     = wb_flags_q[1];
   assign wb_over    = wb_flags_q[0];
   assign wb_illegal = wb_ill_q;

endmodule

// File: tb/tb_ialu_issue.sv
// tb/tb_ialu_issue.sv - self-checking bench for ialu_issue

module tb_ialu_issue;

   logic        clk;
   logic        nreset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [63:0] in_rs1, in_rs2, op_rs1, op_rs2;
   logic        de_add, de_sub, de_sll, de_srl, de_sra, de_and, de_or, de_xor;
   logic        de_sltu, de_slt, de_sext;
   logic [63:0] ia_result;
   logic        ia_zero, ia_carry, ia_neg, ia_over;
   logic        wb_valid, wb_ready;
   logic [4:0]  wb_rd;
   logic [63:0] wb_result;
   logic        wb_zero, wb_carry, wb_neg, wb_over, wb_illegal;

   ialu_issue #(.DW(64)) dut (
      .clk(clk), .nreset(nreset),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .op_rs1(op_rs1), .op_rs2(op_rs2),
      .de_add(de_add), .de_sub(de_sub), .de_sll(de_sll), .de_srl(de_srl),
      .de_sra(de_sra), .de_and(de_and), .de_or(de_or), .de_xor(de_xor),
      .de_sltu(de_sltu), .de_slt(de_slt), .de_sext(de_sext),
      .ia_result(ia_result), .ia_zero(ia_zero), .ia_carry(ia_carry),
      .ia_neg(ia_neg), .ia_over(ia_over),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
      .wb_result(wb_result), .wb_zero(wb_zero), .wb_carry(wb_carry),
      .wb_neg(wb_neg), .wb_over(wb_over), .wb_illegal(wb_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [10:0] de_vec;
   assign de_vec = {de_add, de_sub, de_sll, de_srl, de_sra, de_and, de_or, de_xor,
                    de_sltu, de_slt, de_sext};

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // carry-out and signed overflow of a+b or a-b
   function automatic logic [1:0] arith(input logic [63:0] a, input logic [63:0] b, input logic sub);
      logic [63:0] bb;
      logic [64:0] s;
      bb = sub ? ~b : b;
      s  = {1'b0, a} + {1'b0, bb} + {64'b0, sub};
      return {s[64], (a[63] == bb[63]) && (s[63] != a[63])};
   endfunction

   // ---------------- environment ALU driven by DUT controls ----------------
   logic [63:0] alu_r, alu_sa;
   logic [5:0]  alu_sh;
   logic [1:0]  alu_cf;
   always_comb begin
      alu_sh = de_sext ? {1'b0, op_rs2[4:0]} : op_rs2[5:0];
      alu_sa = de_sext ? {{32{op_rs1[31]}}, op_rs1[31:0]} : op_rs1;
      alu_r  = '0;
      if (de_slt)       alu_r = {63'b0, $signed(op_rs1) < $signed(op_rs2)};
      else if (de_sltu) alu_r = {63'b0, op_rs1 < op_rs2};
      else if (de_sub)  alu_r = op_rs1 - op_rs2;
      else if (de_add)  alu_r = op_rs1 + op_rs2;
      else if (de_sll)  alu_r = op_rs1 << alu_sh;
      else if (de_srl)  alu_r = (de_sext ? {32'b0, op_rs1[31:0]} : op_rs1) >> alu_sh;
      else if (de_sra)  alu_r = $signed(alu_sa) >>> alu_sh;
      else if (de_and)  alu_r = op_rs1 & op_rs2;
      else if (de_or)   alu_r = op_rs1 | op_rs2;
      else if (de_xor)  alu_r = op_rs1 ^ op_rs2;
      if (de_sext) alu_r = {{32{alu_r[31]}}, alu_r[31:0]};
      alu_cf    = (de_add | de_sub) ? arith(op_rs1, op_rs2, de_sub) : 2'b00;
      ia_result = alu_r;
      ia_zero   = (alu_r == 64'd0);
      ia_neg    = alu_r[63];
      ia_carry  = alu_cf[1];
      ia_over   = alu_cf[0];
   end

   // ---------------- reference model: RV64I semantics ----------------
   typedef struct {
      logic        ill;
      logic [4:0]  rd;
      logic [63:0] res;
      logic        z, c, n, o;
   } exp_t;

   function automatic exp_t ref_exec(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] rs2v);
      exp_t        e;
      logic [6:0]  op, f7;
      logic [2:0]  f3;
      logic [63:0] b, r;
      logic [1:0]  cf;
      bit          reg_form, word, ok, subtract;
      int          sh;
      op = ins[6:0]; f7 = ins[31:25]; f3 = ins[14:12];
      reg_form = (op == 7'h33) || (op == 7'h3B);
      word     = (op == 7'h3B) || (op == 7'h1B);
      ok       = reg_form || (op == 7'h13) || (op == 7'h1B);
      b        = reg_form ? rs2v : {{52{ins[31]}}, ins[31:20]};
      sh       = word ? int'(b[4:0]) : int'(b[5:0]);
      if (word && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) ok = 0;
      if (reg_form && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) ok = 0;
      if (!reg_form && f3 == 3'd1)
         ok = ok && (word ? (f7 == 7'h00) : (ins[31:26] == 6'h00));
      if (!reg_form && f3 == 3'd5)
         ok = ok && (word ? (f7 == 7'h00 || f7 == 7'h20) : (ins[31:26] == 6'h00 || ins[31:26] == 6'h10));
      subtract = (f3 == 3'd0 && reg_form && f7 == 7'h20) || f3 == 3'd2 || f3 == 3'd3;
      case (f3)
         3'd0: r = subtract ? a - b : a + b;
         3'd1: r = a << sh;
         3'd2: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
         3'd3: r = (a < b) ? 64'd1 : 64'd0;
         3'd4: r = a ^ b;
         3'd5: begin
            if (ins[30]) r = word ? $signed({{32{a[31]}}, a[31:0]}) >>> sh : $signed(a) >>> sh;
            else         r = word ? {32'b0, a[31:0]} >> sh : a >> sh;
         end
         3'd6: r = a | b;
         default: r = a & b;
      endcase
      if (word) r = {{32{r[31]}}, r[31:0]};
      cf = (f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd3) ? arith(a, b, subtract) : 2'b00;
      e.rd  = ins[11:7];
      e.ill = !ok;
      e.res = ok ? r : 64'd0;
      e.z   = ok && (r == 64'd0);
      e.n   = ok && r[63];
      e.c   = ok && cf[1];
      e.o   = ok && cf[0];
      return e;
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [31:0] w;
      logic [6:0]  op, f7;
      case ($urandom_range(0, 4))
         0: op = 7'h33;
         1: op = 7'h13;
         2: op = 7'h3B;
         3: op = 7'h1B;
         default: op = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
         0, 1: f7 = 7'h00;
         2: f7 = 7'h20;
         default: f7 = 7'($urandom);
      endcase
      w = $urandom;
      w[31:25] = f7;
      w[6:0]   = op;
      return w;
   endfunction

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [31:0] instr;
      logic [63:0] rs1, rs2;
      logic [10:0] de;
      logic        ill;
      logic [4:0]  rd;
      logic [63:0] res;
      logic        z, n;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs[NV];

   task automatic drain();
      in_valid = 1'b0;
      wb_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
   endtask

   exp_t q[$];
   bit   w_has;
   bit   acc, exp_ready;
   exp_t nx;

   initial begin
      vecs[0]  = '{32'h002081B3, 64'd5, 64'd7, 11'h400, 1'b0, 5'd3, 64'd12, 1'b0, 1'b0};
      vecs[1]  = '{32'h402081B3, 64'd5, 64'd7, 11'h600, 1'b0, 5'd3, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b1};
      vecs[2]  = '{32'h0010819B, 64'h7FFFFFFF, 64'd0, 11'h401, 1'b0, 5'd3, 64'hFFFFFFFF80000000, 1'b0, 1'b1};
      vecs[3]  = '{32'h00000000, 64'd9, 64'd9, 11'h000, 1'b1, 5'd0, 64'd0, 1'b0, 1'b0};
      vecs[4]  = '{32'h0020C1B3, 64'hF0F0, 64'hFF00, 11'h008, 1'b0, 5'd3, 64'h0FF0, 1'b0, 1'b0};
      vecs[5]  = '{32'h0020B1B3, 64'd5, 64'd7, 11'h204, 1'b0, 5'd3, 64'd1, 1'b0, 1'b0};
      vecs[6]  = '{32'h0020A1B3, 64'hFFFFFFFFFFFFFFFF, 64'd1, 11'h202, 1'b0, 5'd3, 64'd1, 1'b0, 1'b0};
      vecs[7]  = '{32'h43F0D193, 64'h8000000000000000, 64'd0, 11'h040, 1'b0, 5'd3, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1};
      vecs[8]  = '{32'h0210919B, 64'd1, 64'd1, 11'h000, 1'b1, 5'd3, 64'd0, 1'b0, 1'b0};
      vecs[9]  = '{32'h0020A1BB, 64'd1, 64'd2, 11'h000, 1'b1, 5'd3, 64'd0, 1'b0, 1'b0};
      vecs[10] = '{32'h0020D1BB, 64'hFFFFFFFF80000000, 64'd4, 11'h081, 1'b0, 5'd3, 64'h08000000, 1'b0, 1'b0};
      vecs[11] = '{32'h00208033, 64'd0, 64'd0, 11'h400, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0};
      vecs[12] = '{32'h02009193, 64'd1, 64'd0, 11'h100, 1'b0, 5'd3, 64'h100000000, 1'b0, 1'b0};

      nreset = 1'b0; in_valid = 1'b0; wb_ready = 1'b0;
      in_instr = '0; in_rs1 = '0; in_rs2 = '0;
      #2;
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_de", de_vec, 0);
      chk("rst_wb_result", wb_result, 0);
      @(posedge clk); #1;
      nreset = 1'b1;

      // table-driven single beats
      for (int i = 0; i < NV; i++) begin
         in_valid = 1'b1; wb_ready = 1'b1;
         in_instr = vecs[i].instr; in_rs1 = vecs[i].rs1; in_rs2 = vecs[i].rs2;
         @(posedge clk); #1;
         in_valid = 1'b0;
         chk($sformatf("vec%0d_de", i), de_vec, vecs[i].de);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_wb_valid", i), wb_valid, 1);
         chk($sformatf("vec%0d_result", i), wb_result, vecs[i].res);
         chk($sformatf("vec%0d_rd", i), wb_rd, vecs[i].rd);
         chk($sformatf("vec%0d_illegal", i), wb_illegal, vecs[i].ill);
         chk($sformatf("vec%0d_zn", i), {wb_zero, wb_neg}, {vecs[i].z, vecs[i].n});
         @(posedge clk); #1;
         chk($sformatf("vec%0d_drained", i), wb_valid, 0);
      end

      // backpressure: three back-to-back adds with W stalled
      drain();
      wb_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h002081B3;
      in_rs1 = 64'd1; in_rs2 = 64'd2;
      #3; chk("bp_ready_a", in_ready, 1);
      @(posedge clk); #1;
      in_rs1 = 64'd10; in_rs2 = 64'd20;
      #3; chk("bp_ready_b", in_ready, 1);
      @(posedge clk); #1;
      in_rs1 = 64'd100; in_rs2 = 64'd200;
      #3; chk("bp_full", in_ready, 0);
      chk("bp_head", wb_result, 3);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1; #3;
         chk($sformatf("bp_hold%0d_ready", k), in_ready, 0);
         chk($sformatf("bp_hold%0d_valid", k), wb_valid, 1);
         chk($sformatf("bp_hold%0d_result", k), wb_result, 3);
      end
      @(posedge clk); #1;
      wb_ready = 1'b1;
      #3; chk("bp_release_ready", in_ready, 1);
      chk("bp_out_a", wb_result, 3);
      @(posedge clk); #1;
      in_valid = 1'b0;
      #3; chk("bp_out_b", wb_result, 30);
      chk("bp_out_b_valid", wb_valid, 1);
      @(posedge clk); #1; #3;
      chk("bp_out_c", wb_result, 300);
      chk("bp_out_c_valid", wb_valid, 1);
      @(posedge clk); #1; #3;
      chk("bp_empty", wb_valid, 0);

      // asynchronous reset with both stages full
      @(posedge clk); #1;
      wb_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h002081B3;
      in_rs1 = 64'd1; in_rs2 = 64'd2;
      @(posedge clk); #1;
      in_rs1 = 64'd3; in_rs2 = 64'd4;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("ar_pre_wb_valid", wb_valid, 1);
      chk("ar_pre_in_ready", in_ready, 0);
      #1 nreset = 1'b0;
      #1;
      chk("ar_wb_valid", wb_valid, 0);
      chk("ar_in_ready", in_ready, 1);
      chk("ar_de", de_vec, 0);
      chk("ar_wb_result", wb_result, 0);
      @(posedge clk); #1;
      nreset = 1'b1; wb_ready = 1'b1;
      @(posedge clk); #1;
      chk("ar_no_stale0", wb_valid, 0);
      @(posedge clk); #1;
      chk("ar_no_stale1", wb_valid, 0);
      in_valid = 1'b1; in_rs1 = 64'd40; in_rs2 = 64'd2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("ar_first_d", wb_valid, 0);
      chk("ar_first_de", de_vec, 11'h400);
      @(posedge clk); #1;
      chk("ar_first_valid", wb_valid, 1);
      chk("ar_first_result", wb_result, 42);
      drain();

      // randomized traffic against the queue model
      q.delete();
      w_has = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         wb_ready = ($urandom_range(0, 3) != 0);
         in_instr = gen_instr();
         in_rs1   = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 9)) : {$urandom, $urandom};
         in_rs2   = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 9)) : {$urandom, $urandom};
         #3;
         exp_ready = (q.size() < 2) || wb_ready;
         chk("rnd_in_ready", in_ready, exp_ready);
         chk("rnd_wb_valid", wb_valid, w_has);
         if (w_has) begin
            chk("rnd_result", wb_result, q[0].res);
            chk("rnd_rd", wb_rd, q[0].rd);
            chk("rnd_illegal", wb_illegal, q[0].ill);
            chk("rnd_flags", {wb_zero, wb_carry, wb_neg, wb_over}, {q[0].z, q[0].c, q[0].n, q[0].o});
         end
         if (q.size() == int'(w_has)) chk("rnd_de_idle", de_vec, 0);
         acc = in_valid && exp_ready;
         nx  = ref_exec(in_instr, in_rs1, in_rs2);
         @(posedge clk);
         if (w_has && wb_ready) begin
            void'(q.pop_front());
            w_has = 0;
         end
         if (!w_has && q.size() > 0) w_has = 1;
         if (acc) q.push_back(nx);
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
